// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the sequential digit multiplier.
//                Provides the controller state encoding, the digit width,
//                and a helper that selects one 4-bit digit from an operand.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    // Width of one operand digit fed to the shared 4x4 multiplier.
    localparam int DIG  = 4;
    // Widest operand the digit selector supports (four digits).
    localparam int MAXW = 16;

    // Controller state encoding with an explicit 2-bit width.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    // Returns digit number idx (0 = least significant) of a zero-extended operand.
    function automatic logic [DIG-1:0] dig_sel(input logic [MAXW-1:0] v,
                                               input logic [1:0]      idx);
        return v[{idx, 2'b00} +: DIG];
    endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul
//  Description : Combinational 4x4 unsigned array multiplier.
//  Ports       : a  [3:0] in   multiplicand digit
//                b  [3:0] in   multiplier digit
//                p  [7:0] out  product a*b
//  Revision    : 1.0  initial release
// ============================================================================
module mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] w_pp [4];

    // One shifted partial product per multiplier bit.
    for (genvar g = 0; g < 4; g++) begin : g_pp
        assign w_pp[g] = b[g] ? ({4'b0000, a} << g) : 8'd0;
    end

    // 15*15 = 225 fits in 8 bits, so the truncating sum is exact.
    assign p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];

endmodule : mul
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : Sequential WxW unsigned multiplier. Issues one 4-bit digit
//                pair per clock to a shared 4x4 multiplier and accumulates
//                the shifted partial products into a 2W-bit result.
//                Valid/ready on both the operand and the product side.
//  Ports       : clk        in   clock, rising edge
//                rst_n      in   asynchronous active-low reset
//                in_valid   in   operand pair valid
//                in_ready   out  operand pair can be accepted
//                in_a,in_b  in   W-bit unsigned operands
//                abort      in   synchronous cancel of the current operation
//                out_valid  out  product valid
//                out_ready  in   consumer accepts the product
//                out_p      out  2W-bit product (0 while out_valid is low)
//                busy       out  controller is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             busy
);

    localparam int c_D     = W / DIG;
    localparam int c_NSTEP = c_D * c_D;
    localparam int c_KW    = (c_NSTEP > 1) ? $clog2(c_NSTEP) : 1;
    localparam logic [c_KW-1:0] c_DK   = c_KW'(c_D);
    localparam logic [c_KW-1:0] c_KMAX = c_KW'(c_NSTEP - 1);

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [2*W-1:0]    r_acc;
    logic [c_KW-1:0]   r_k;

    logic [c_KW-1:0]   w_i;
    logic [c_KW-1:0]   w_j;
    logic [3:0]        w_da;
    logic [3:0]        w_db;
    logic [7:0]        w_prod;
    logic [2:0]        w_sum;
    logic [4:0]        w_sh;
    logic [2*W-1:0]    w_term;
    logic              w_last;
    logic              w_accept;

    // Single step counter: i (a digit) runs fastest, j (b digit) slowest.
    assign w_i    = r_k % c_DK;
    assign w_j    = r_k / c_DK;
    assign w_last = (r_k == c_KMAX);

    assign w_da = dig_sel(MAXW'(r_a), 2'(w_i));
    assign w_db = dig_sel(MAXW'(r_b), 2'(w_j));

    mul u_mul (
        .a (w_da),
        .b (w_db),
        .p (w_prod)
    );

    // Digit product weight is 16^(i+j).
    assign w_sum  = 3'(w_i) + 3'(w_j);
    assign w_sh   = {w_sum, 2'b00};
    assign w_term = (2*W)'(w_prod) << w_sh;

    assign in_ready  = (r_state == IDLE) && !abort;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign out_p     = out_valid ? r_acc : '0;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: begin
                if (abort)       w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE: begin
                if (abort || out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_k   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                CALC: begin
                    if (abort) begin
                        r_acc <= '0;
                        r_k   <= '0;
                    end else begin
                        r_acc <= r_acc + w_term;
                        r_k   <= w_last ? '0 : r_k + 1'b1;
                    end
                end
                DONE: begin
                    // Leaving DONE for any reason clears the result.
                    if (abort || out_ready) r_acc <= '0;
                end
                default: begin
                    r_acc <= '0;
                    r_k   <= '0;
                end
            endcase
        end
    end

endmodule : mul_seq_ctrl
`default_nettype wire
